dm_responder: RTL and testbench

//  Data-memory slave at the far end of the M-stage data port: serves m_data_rdata, commits byte-enabled writes.

---
 rtl/mips_defs.sv | 40 ++++
 rtl/trace_fifo.sv | 76 +++++++
 rtl/dm_responder.sv | 159 +++++++++++++++
 tb/tb_dm_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared definitions for the data-memory responder.
// Contents:
//   DM_ADDR_WIDTH / DM_BASE_ADDR / DM_TRACE_DEPTH : default geometry
//   ST_INIT / ST_RUN                              : responder state encoding
//   TRACE_REC_W, trace_rec_t                      : one write-trace record
//   lane_merge()                                  : byte-lane write merge
package mips_defs;

  localparam int unsigned DM_ADDR_WIDTH  = 32'd12;
  localparam logic [31:0] DM_BASE_ADDR   = 32'h0000_0000;
  localparam int unsigned DM_TRACE_DEPTH = 32'd8;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned TRACE_REC_W = 32'd96;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byteen);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (byteen[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding write-trace records; head is shown without a
// fall-through path, so a push into an empty FIFO appears next cycle.
// Ports:
//   clk, reset  : clock, synchronous active-low reset (clears pointers/count)
//   push, din   : enqueue request and record; accepted when not full, or
//                 when full but a pop happens in the same cycle
//   pop         : dequeue request; ignored while empty
//   dout        : head record
//   full, empty : occupancy flags
module trace_fifo #(
  parameter int unsigned WIDTH = 32'd96,
  parameter int unsigned DEPTH = 32'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: a full FIFO still accepts a push if it also pops.
  always_comb begin
    do_pop_s  = pop && (count_r != CNT_ZERO);
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == CNT_ZERO);
  assign dout  = store_r[rd_ptr_r];

  // Record storage; not reset, only pointer-addressed slots are ever read.
  always_ff @(posedge clk) begin
    if (reset && do_push_s) begin
      store_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory slave for the M-stage data port. Zero-fills its array after
// reset, then serves combinational reads and byte-enabled writes, logging
// every committed write into a trace FIFO.
// Ports:
//   clk, reset                    : clock, synchronous active-low reset
//   m_inst_addr                   : PC of the M-stage instruction (trace tag)
//   m_data_addr / _wdata / _byteen: request; byteen==0 is a plain read
//   m_data_rdata                  : word at m_data_addr (pre-write value)
//   init_done                     : zero-fill sweep finished
//   trace_valid/ready, trace_pc/addr/data : trace FIFO head handshake
//   trace_overflow                : sticky, a record was dropped
//   addr_err, err_addr            : sticky out-of-window flag, first address
module dm_responder
  import mips_defs::*;
#(
  parameter int unsigned ADDR_WIDTH  = DM_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR,
  parameter int unsigned TRACE_DEPTH = DM_TRACE_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        init_done,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow,
  output logic        addr_err,
  output logic [31:0] err_addr
);

  localparam int unsigned WORDS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [29-ADDR_WIDTH:0] HI_ZERO = {(30-ADDR_WIDTH){1'b0}};

  logic [31:0]           mem_r [WORDS];
  logic [0:0]            state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  trace_overflow_r;
  logic                  addr_err_r;
  logic [31:0]           err_addr_r;

  logic [31:0]           off_s;
  logic                  in_range_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  run_s;
  logic [31:0]           old_word_s;
  logic [31:0]           merged_s;
  logic [31:0]           rdata_s;
  logic                  wr_en_s;
  logic                  oor_s;
  logic                  addr_lane_unused_s;
  trace_rec_t            rec_in_s;
  trace_rec_t            rec_out_s;
  logic                  trace_full_s;
  logic                  trace_empty_s;

  // Decode the request against the window and form read data / merged word.
  always_comb begin
    off_s      = m_data_addr - BASE_ADDR;
    in_range_s = (off_s[31:ADDR_WIDTH+2] == HI_ZERO);
    idx_s      = off_s[ADDR_WIDTH+1:2];
    run_s      = (state_r == ST_RUN);
    old_word_s = mem_r[idx_s];
    merged_s   = lane_merge(old_word_s, m_data_wdata, m_data_byteen);
    oor_s      = run_s && !in_range_s;
    if (run_s && in_range_s) begin
      wr_en_s = (m_data_byteen != 4'b0000);
      rdata_s = old_word_s;
    end else begin
      wr_en_s = 1'b0;
      rdata_s = 32'h0000_0000;
    end
  end

  // Byte offset within a word plays no part; byteen alone selects lanes.
  assign addr_lane_unused_s = ^off_s[1:0];

  // Trace record carries the word-aligned byte address, not the raw one.
  always_comb begin
    rec_in_s.pc   = m_inst_addr;
    rec_in_s.addr = BASE_ADDR + {HI_ZERO, idx_s, 2'b00};
    rec_in_s.data = merged_s;
  end

  // Array write port: zero-fill sweep in INIT, requester writes in RUN.
  always_ff @(posedge clk) begin
    if (reset == 1'b1) begin
      if (state_r == ST_INIT) begin
        mem_r[cnt_r] <= 32'h0000_0000;
      end else if (wr_en_s) begin
        mem_r[idx_s] <= merged_s;
      end
    end
  end

  // Sweep FSM, first-error latch and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      state_r          <= ST_INIT;
      cnt_r            <= CNT_ZERO;
      trace_overflow_r <= 1'b0;
      addr_err_r       <= 1'b0;
      err_addr_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
      if (oor_s && !addr_err_r) begin
        addr_err_r <= 1'b1;
        err_addr_r <= m_data_addr;
      end
      // A full FIFO only loses the record when nothing leaves this cycle.
      if (wr_en_s && trace_full_s && !trace_ready) begin
        trace_overflow_r <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_en_s),
    .pop   (trace_ready),
    .din   (rec_in_s),
    .dout  (rec_out_s),
    .full  (trace_full_s),
    .empty (trace_empty_s)
  );

  assign m_data_rdata   = rdata_s;
  assign init_done      = run_s;
  assign trace_valid    = !trace_empty_s;
  assign trace_pc       = rec_out_s.pc;
  assign trace_addr     = rec_out_s.addr;
  assign trace_data     = rec_out_s.data;
  assign trace_overflow = trace_overflow_r;
  assign addr_err       = addr_err_r;
  assign err_addr       = err_addr_r;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed stimulus, a queue/array reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_dm_responder;

  localparam int          WORDS = 4096;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        init_done;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        addr_err;
  logic [31:0] err_addr;

  dm_responder #(
    .ADDR_WIDTH  (12),
    .BASE_ADDR   (BASE),
    .TRACE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m_inst_addr    (m_inst_addr),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_data_rdata   (m_data_rdata),
    .init_done      (init_done),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow),
    .addr_err       (addr_err),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  int          since = 0;          // clock edges since reset released
  logic [31:0] mm [WORDS];
  rec_t        q [$];
  bit          m_ovf = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_err_addr = 32'h0;

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(WORDS * 4);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 32'd4);
  endfunction

  task automatic model_step();
    logic [31:0] merged;
    rec_t        r;
    int          idx;
    if (reset === 1'b0) begin
      since = 0;
      foreach (mm[i]) mm[i] = 32'h0;
      q.delete();
      m_ovf = 1'b0;
      m_err = 1'b0;
      m_err_addr = 32'h0;
    end else if (since < WORDS) begin
      since++;
    end else begin
      if (q.size() > 0 && trace_ready === 1'b1) void'(q.pop_front());
      if (!in_win(m_data_addr)) begin
        if (!m_err) begin
          m_err = 1'b1;
          m_err_addr = m_data_addr;
        end
      end else if (m_data_byteen != 4'b0000) begin
        idx = word_of(m_data_addr);
        merged = mm[idx];
        for (int k = 0; k < 4; k++)
          if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
        mm[idx] = merged;
        r.pc   = m_inst_addr;
        r.addr = BASE + 32'(idx * 4);
        r.data = merged;
        if (q.size() < DEPTH) q.push_back(r);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    foreach (mm[i]) mm[i] = 32'h0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (since >= WORDS && in_win(m_data_addr)) exp_rd = mm[word_of(m_data_addr)];
        else exp_rd = 32'h0;
        chk("m_rdata", m_data_rdata, exp_rd);
        chk("m_init_done", 32'(init_done), (since >= WORDS) ? 32'd1 : 32'd0);
        chk("m_trace_valid", 32'(trace_valid), (q.size() > 0) ? 32'd1 : 32'd0);
        chk("m_overflow", 32'(trace_overflow), 32'(m_ovf));
        chk("m_addr_err", 32'(addr_err), 32'(m_err));
        chk("m_err_addr", err_addr, m_err_addr);
        if (q.size() > 0) begin
          chk("m_trace_pc", trace_pc, q[0].pc);
          chk("m_trace_addr", trace_addr, q[0].addr);
          chk("m_trace_data", trace_data, q[0].data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] pc, input logic rdy);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    m_data_addr   = a;
    m_data_wdata  = wd;
    m_data_byteen = be;
    m_inst_addr   = pc;
    trace_ready   = rdy;
  endtask

  task automatic idle(input logic rdy);
    step(32'h0, 32'h0, 4'b0000, 32'h0, rdy);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset         = 1'b0;
    m_data_addr   = 32'h0;
    m_data_byteen = 4'b0000;
    trace_ready   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; m_inst_addr = 32'h0; m_data_addr = 32'h0;
    m_data_wdata = 32'h0; m_data_byteen = 4'b0000; trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_valid", 32'(trace_valid), 32'd0);

    // INIT: 4096 cycles; writes and out-of-window accesses must be ignored.
    for (int i = 0; i < WORDS - 1; i++) begin
      if (i < 16) step(32'(i * 4), 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
      else if (i < 32) step(32'h0000_4000, 32'h0, 4'b1111, 32'h0, 1'b0);
      else step(32'(i * 4), 32'h0, 4'b0000, 32'h0, 1'b0);
    end
    @(negedge clk);
    chk("init_done_4096", 32'(init_done), 32'd0);
    chk("init_rdata_zero", m_data_rdata, 32'h0);
    idle(1'b0);
    @(negedge clk);
    chk("init_done_4097", 32'(init_done), 32'd1);
    chk("init_no_addr_err", 32'(addr_err), 32'd0);
    chk("init_no_trace", 32'(trace_valid), 32'd0);

    // Every word reads zero after the sweep.
    for (int i = 0; i < WORDS; i++) step(32'(i * 4), 32'h0, 4'b0000, 32'h0, 1'b0);

    // Partial write merge; same-cycle read returns the old word.
    step(32'h0000_3000, 32'h1122_3344, 4'b1111, 32'h0000_0100, 1'b0);
    step(32'h0000_3000, 32'hAABB_CCDD, 4'b0011, 32'h0000_0104, 1'b0);
    @(negedge clk);
    chk("same_cycle_old", m_data_rdata, 32'h1122_3344);
    step(32'h0000_3002, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("merged_rdata", m_data_rdata, 32'h1122_CCDD);
    chk("head0_pc", trace_pc, 32'h0000_0100);
    chk("head0_data", trace_data, 32'h1122_3344);
    step(32'h0000_3000, 32'h0, 4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    chk("head0_held", trace_data, 32'h1122_3344);
    idle(1'b1);
    @(negedge clk);
    chk("head1_pc", trace_pc, 32'h0000_0104);
    chk("head1_addr", trace_addr, 32'h0000_3000);
    chk("head1_data", trace_data, 32'h1122_CCDD);
    idle(1'b0);
    @(negedge clk);
    chk("drained", 32'(trace_valid), 32'd0);

    // Nine writes into an 8-deep FIFO with no consumer.
    for (int i = 0; i < 9; i++)
      step(32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'b1111, 32'h0040_0000 + 32'(i * 4), 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("ovf_set", 32'(trace_overflow), 32'd1);
    for (int k = 0; k < 8; k++) begin
      idle(1'b1);
      @(negedge clk);
      chk("pop_order_data", trace_data, 32'hA000_0000 + 32'(k));
      chk("pop_order_pc", trace_pc, 32'h0040_0000 + 32'(k * 4));
    end
    idle(1'b0);
    @(negedge clk);
    chk("ovf_empty", 32'(trace_valid), 32'd0);

    // Out-of-window accesses: first address latched, nothing written.
    step(32'h0000_4000, 32'h5555_5555, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    chk("oor_rdata", m_data_rdata, 32'h0);
    step(32'h0000_5000, 32'h0, 4'b0000, 32'h0, 1'b0);
    step(32'h0000_0000, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("oor_err", 32'(addr_err), 32'd1);
    chk("oor_err_addr", err_addr, 32'h0000_4000);
    chk("oor_no_trace", 32'(trace_valid), 32'd0);
    chk("oor_word0", m_data_rdata, 32'h0);

    // Mid-run reset with records queued and flags set.
    step(32'h0000_0010, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
    step(32'h0000_0014, 32'h8765_4321, 4'b1111, 32'h0, 1'b0);
    pulse_reset();
    idle(1'b0);
    @(negedge clk);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_ovf", 32'(trace_overflow), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_err_addr", err_addr, 32'h0);
    repeat (WORDS - 1) idle(1'b0);
    step(32'h0000_3000, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("rezero_3000", m_data_rdata, 32'h0);
    step(32'h0000_0100, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("rezero_0100", m_data_rdata, 32'h0);
    step(32'h0000_0010, 32'h0, 4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    chk("rezero_0010", m_data_rdata, 32'h0);

    // Full FIFO with simultaneous push and pop: no drop, no overflow.
    for (int i = 0; i < 8; i++)
      step(32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i), 4'b1111, 32'h0, 1'b0);
    step(32'h220, 32'hB000_0008, 4'b1111, 32'h0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("fpp_ovf", 32'(trace_overflow), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      idle(1'b1);
      @(negedge clk);
      chk("fpp_order", trace_data, 32'hB000_0000 + 32'(k));
    end
    idle(1'b0);
    @(negedge clk);
    chk("fpp_count8", 32'(trace_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
